radiation_event_histogrammer: RTL and testbench

//  AXI-Stream slave that consumes the 32-bit pulse-event words emitted by the detector core.

---
 rtl/radiation_event_histogrammer.sv | 167 ++++++++++++++++
 tb/tb_radiation_event_histogrammer.sv | 359 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/radiation_event_histogrammer.sv
// AXI-Stream event histogrammer: bins ADC amplitudes into a RAM with a 3-stage RMW pipeline.
// Optional feature macro: HIST_SATURATE_EN (saturating bins + sticky sat_flag); default build wraps.
module radiation_event_histogrammer #(
  parameter int ADC_WIDTH       = 12,
  parameter int HIST_ADDR_WIDTH = 10,
  parameter int HIST_DATA_WIDTH = 32
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [31:0]                s_axis_tdata,
  input  logic                       s_axis_tvalid,
  output logic                       s_axis_tready,
  input  logic                       rd_req,
  input  logic [HIST_ADDR_WIDTH-1:0] rd_addr,
  output logic                       rd_valid,
  output logic [HIST_DATA_WIDTH-1:0] rd_data,
  input  logic                       clear_req,
  output logic                       busy,
  output logic [31:0]                total_events,
  output logic [15:0]                dropped_events,
  output logic                       sat_flag
);

  localparam int NBINS = 1 << HIST_ADDR_WIDTH;

  typedef enum logic [1:0] {
    ST_CLEAR = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t                     state_q;
  logic [HIST_ADDR_WIDTH-1:0] clr_addr_q;
  logic                       s1_ev_q;
  logic                       s1_rd_q;
  logic [HIST_ADDR_WIDTH-1:0] s1_addr_q;
  logic                       s2_ev_q;
  logic [HIST_ADDR_WIDTH-1:0] s2_addr_q;
  logic [HIST_DATA_WIDTH-1:0] s2_base_q;
  logic                       rd_valid_q;
  logic [HIST_DATA_WIDTH-1:0] rd_data_q;
  logic [31:0]                total_q;
  logic [15:0]                dropped_q;
  logic [HIST_DATA_WIDTH-1:0] mem [0:NBINS-1];

  logic                       accept_d;
  logic                       well_formed_d;
  logic [HIST_ADDR_WIDTH-1:0] in_bin_d;
  logic [HIST_DATA_WIDTH-1:0] s1_base_d;
  logic [HIST_DATA_WIDTH-1:0] s2_new_d;
  logic                       drain_done_d;
  logic [31:0]                tdata_unused;

  assign tdata_unused  = s_axis_tdata;
  assign s_axis_tready = (state_q == ST_RUN) && !rd_req;
  assign accept_d      = s_axis_tvalid && s_axis_tready;
  assign well_formed_d = (s_axis_tdata[31:ADC_WIDTH] == {(32-ADC_WIDTH){1'b0}});
  assign in_bin_d      = s_axis_tdata[ADC_WIDTH-1 -: HIST_ADDR_WIDTH];
  assign drain_done_d  = (state_q == ST_DRAIN) && !s1_ev_q && !s1_rd_q;

  // The S2 write lands in the same edge as the S1 read, so a matching S2 result is forwarded.
  assign s1_base_d = (s2_ev_q && (s2_addr_q == s1_addr_q)) ? s2_new_d : mem[s1_addr_q];

  always_comb begin
    s2_new_d = s2_base_q + {{(HIST_DATA_WIDTH-1){1'b0}}, 1'b1};
`ifdef HIST_SATURATE_EN
    if (&s2_base_q) begin
      s2_new_d = s2_base_q;
    end else begin
      s2_new_d = s2_base_q + {{(HIST_DATA_WIDTH-1){1'b0}}, 1'b1};
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_CLEAR;
      clr_addr_q <= {HIST_ADDR_WIDTH{1'b0}};
      s1_ev_q    <= 1'b0;
      s1_rd_q    <= 1'b0;
      s1_addr_q  <= {HIST_ADDR_WIDTH{1'b0}};
      s2_ev_q    <= 1'b0;
      s2_addr_q  <= {HIST_ADDR_WIDTH{1'b0}};
      s2_base_q  <= {HIST_DATA_WIDTH{1'b0}};
      rd_valid_q <= 1'b0;
      rd_data_q  <= {HIST_DATA_WIDTH{1'b0}};
      total_q    <= 32'd0;
      dropped_q  <= 16'd0;
    end else begin
      s1_ev_q    <= accept_d && well_formed_d;
      s1_rd_q    <= rd_req && (state_q == ST_RUN);
      s1_addr_q  <= rd_req ? rd_addr : in_bin_d;
      s2_ev_q    <= s1_ev_q;
      s2_addr_q  <= s1_addr_q;
      s2_base_q  <= s1_base_d;
      rd_valid_q <= s1_rd_q;
      if (s1_rd_q) begin
        rd_data_q <= s1_base_d;
      end
      if (accept_d && well_formed_d) begin
        total_q <= total_q + 32'd1;
      end
      if (accept_d && !well_formed_d && (dropped_q != 16'hFFFF)) begin
        dropped_q <= dropped_q + 16'd1;
      end
      case (state_q)
        ST_CLEAR: begin
          clr_addr_q <= clr_addr_q + {{(HIST_ADDR_WIDTH-1){1'b0}}, 1'b1};
          if (clr_addr_q == {HIST_ADDR_WIDTH{1'b1}}) begin
            state_q <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (clear_req) begin
            state_q <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          // S2 may still be writing as we leave; CLEAR overwrites that bin anyway.
          if (drain_done_d) begin
            state_q    <= ST_CLEAR;
            clr_addr_q <= {HIST_ADDR_WIDTH{1'b0}};
            total_q    <= 32'd0;
            dropped_q  <= 16'd0;
          end
        end
        default: begin
          state_q    <= ST_CLEAR;
          clr_addr_q <= {HIST_ADDR_WIDTH{1'b0}};
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (state_q == ST_CLEAR) begin
      mem[clr_addr_q] <= {HIST_DATA_WIDTH{1'b0}};
    end else if (s2_ev_q) begin
      mem[s2_addr_q] <= s2_new_d;
    end
  end

`ifdef HIST_SATURATE_EN
  logic sat_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sat_q <= 1'b0;
    end else if (drain_done_d) begin
      sat_q <= 1'b0;
    end else if (s2_ev_q && (&s2_base_q)) begin
      sat_q <= 1'b1;
    end
  end

  assign sat_flag = sat_q;
`else
  assign sat_flag = 1'b0;
`endif

  assign rd_valid       = rd_valid_q;
  assign rd_data        = rd_data_q;
  assign busy           = (state_q == ST_CLEAR);
  assign total_events   = total_q;
  assign dropped_events = dropped_q;

endmodule

// File: tb/tb_radiation_event_histogrammer.sv
// Scoreboard bench for radiation_event_histogrammer (8-bit bins so saturation is reachable by hits).
module tb_radiation_event_histogrammer;
  localparam int AW = 10;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [31:0]   s_axis_tdata;
  logic          s_axis_tvalid;
  logic          s_axis_tready;
  logic          rd_req;
  logic [AW-1:0] rd_addr;
  logic          rd_valid;
  logic [DW-1:0] rd_data;
  logic          clear_req;
  logic          busy;
  logic [31:0]   total_events;
  logic [15:0]   dropped_events;
  logic          sat_flag;

  radiation_event_histogrammer #(
    .ADC_WIDTH(12), .HIST_ADDR_WIDTH(AW), .HIST_DATA_WIDTH(DW)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_valid(rd_valid), .rd_data(rd_data),
    .clear_req(clear_req), .busy(busy),
    .total_events(total_events), .dropped_events(dropped_events), .sat_flag(sat_flag)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model
  logic [DW-1:0] model [0:(1<<AW)-1];
  int   m_total;
  int   m_dropped;
  logic m_sat;

  typedef struct {
    logic [DW-1:0] data;
    int            cyc;
    int            addr;
  } rd_exp_t;
  rd_exp_t sb[$];
  rd_exp_t mon_e;

  // Scoreboard: every rd_valid must match the oldest outstanding read, in value and in timing.
  always @(negedge clk) begin
    if (rd_valid === 1'b1) begin
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL rd_unexpected cyc=%0d rd_data=%0d, required no rd_valid", cyc, rd_data);
      end else begin
        mon_e = sb.pop_front();
        if (rd_data !== mon_e.data || cyc != mon_e.cyc) begin
          failures++;
          $display("FAIL rd_bin%0d got data=%0d at cyc=%0d, required data=%0d at cyc=%0d",
                   mon_e.addr, rd_data, cyc, mon_e.data, mon_e.cyc);
        end
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear;
    for (int i = 0; i < (1<<AW); i++) model[i] = '0;
    m_total = 0;
    m_dropped = 0;
    m_sat = 1'b0;
  endtask

  task automatic model_hit(input logic [31:0] w);
    logic [AW-1:0] b;
    if (w[31:12] == 20'd0) begin
      m_total++;
      b = w[11:2];
`ifdef HIST_SATURATE_EN
      if (model[b] == {DW{1'b1}}) m_sat = 1'b1;
      else model[b] = model[b] + 8'd1;
`else
      model[b] = model[b] + 8'd1;
`endif
    end else if (m_dropped < 65535) begin
      m_dropped++;
    end
  endtask

  // Holds tvalid until accepted; leaves tvalid high so consecutive calls stream back-to-back.
  task automatic send(input logic [31:0] w);
    int n = 0;
    s_axis_tdata = w;
    s_axis_tvalid = 1'b1;
    #1;
    while (s_axis_tready !== 1'b1 && n < 2000) begin
      tick;
      n++;
    end
    if (n >= 2000) begin
      checks++;
      failures++;
      $display("FAIL send_timeout word=%h tready=%b, required tready=1 within 2000 cycles", w, s_axis_tready);
    end else begin
      model_hit(w);
    end
    tick;
  endtask

  task automatic issue_read(input logic [AW-1:0] a);
    rd_exp_t e;
    rd_req = 1'b1;
    rd_addr = a;
    e.data = model[a];
    e.cyc = cyc + 2;
    e.addr = int'(a);
    sb.push_back(e);
    tick;
    rd_req = 1'b0;
  endtask

  task automatic wait_reads;
    int n = 0;
    while (sb.size() != 0 && n < 10) begin
      tick;
      n++;
    end
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL rd_missing outstanding=%0d, required 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic wait_clear_done(input string name);
    int n = 0;
    int bad_ready = 0;
    while (busy === 1'b1 && n < 2000) begin
      if (s_axis_tready !== 1'b0) bad_ready++;
      tick;
      n++;
    end
    checks++;
    if (n != 1024 || bad_ready != 0) begin
      failures++;
      $display("FAIL %s busy_cycles=%0d tready_high=%0d, required 1024 and 0", name, n, bad_ready);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; s_axis_tvalid = 1'b1; s_axis_tdata = 32'd0;
    rd_req = 1'b0; rd_addr = '0; clear_req = 1'b0;
    model_clear();
    repeat (3) tick;
    checks++;
    if ({s_axis_tready, busy, rd_valid, sat_flag} !== 4'b0100) begin
      failures++;
      $display("FAIL reset_flags tready,busy,rd_valid,sat=%b, required 0100",
               {s_axis_tready, busy, rd_valid, sat_flag});
    end
    checks++;
    if (total_events !== 32'd0 || dropped_events !== 16'd0 || rd_data !== 8'd0) begin
      failures++;
      $display("FAIL reset_values total=%0d dropped=%0d rd_data=%0d, required 0 0 0",
               total_events, dropped_events, rd_data);
    end
    rst_n = 1'b1;
    wait_clear_done("reset_clear");
    checks++;
    if (s_axis_tready !== 1'b1) begin
      failures++;
      $display("FAIL reset_run_ready tready=%b, required 1", s_axis_tready);
    end
    model_hit(32'd0);
    tick;
    s_axis_tvalid = 1'b0;
    issue_read(10'd5);
    issue_read(10'd0);
    wait_reads();
  endtask

  task automatic test_same_bin;
    int c0 = cyc;
    for (int i = 0; i < 8; i++) send(32'h0000_0FFF);
    s_axis_tvalid = 1'b0;
    checks++;
    if (cyc - c0 != 8) begin
      failures++;
      $display("FAIL same_bin_throughput cycles=%0d, required 8", cyc - c0);
    end
    tick;
    checks++;
    if (total_events !== 32'(m_total)) begin
      failures++;
      $display("FAIL same_bin_total total=%0d, required %0d", total_events, m_total);
    end
    issue_read(10'd1023);
    wait_reads();
  endtask

  task automatic test_back_to_back;
    send(32'h0000_000C);
    send(32'h0000_000C);
    send(32'h0000_0010);
    send(32'h0000_000C);
    s_axis_tvalid = 1'b0;
    issue_read(10'd3);
    issue_read(10'd4);
    wait_reads();
  endtask

  task automatic test_malformed;
    send(32'h0001_0800);
    s_axis_tvalid = 1'b0;
    tick;
    checks++;
    if (dropped_events !== 16'(m_dropped) || total_events !== 32'(m_total)) begin
      failures++;
      $display("FAIL malformed_counters dropped=%0d total=%0d, required %0d %0d",
               dropped_events, total_events, m_dropped, m_total);
    end
    issue_read(10'd512);
    wait_reads();
  endtask

  task automatic test_read_priority;
    rd_exp_t e;
    s_axis_tdata = 32'h0000_000C;
    s_axis_tvalid = 1'b1;
    rd_req = 1'b1;
    rd_addr = 10'd3;
    #1;
    e.data = model[3]; e.cyc = cyc + 2; e.addr = 3;
    sb.push_back(e);
    checks++;
    if (s_axis_tready !== 1'b0) begin
      failures++;
      $display("FAIL prio_tready_during_read tready=%b, required 0", s_axis_tready);
    end
    tick;
    rd_req = 1'b0;
    #1;
    checks++;
    if (s_axis_tready !== 1'b1) begin
      failures++;
      $display("FAIL prio_tready_after_read tready=%b, required 1", s_axis_tready);
    end else begin
      model_hit(32'h0000_000C);
    end
    tick;
    s_axis_tvalid = 1'b0;
    issue_read(10'd3);
    wait_reads();
  endtask

  task automatic test_saturate;
    while (model[0] != {DW{1'b1}}) send(32'd0);
    s_axis_tvalid = 1'b0;
    issue_read(10'd0);
    wait_reads();
    checks++;
    if (sat_flag !== 1'b0) begin
      failures++;
      $display("FAIL sat_before_hit sat_flag=%b, required 0", sat_flag);
    end
    send(32'd0);
    s_axis_tvalid = 1'b0;
    tick;
    tick;
    issue_read(10'd0);
    wait_reads();
    checks++;
    if (sat_flag !== m_sat) begin
      failures++;
      $display("FAIL sat_after_hit sat_flag=%b, required %b", sat_flag, m_sat);
    end
  endtask

  task automatic test_clear;
    int n = 0;
    issue_read(10'd1023);
    clear_req = 1'b1;
    tick;
    clear_req = 1'b0;
    while (busy !== 1'b1 && n < 10) begin
      tick;
      n++;
    end
    wait_reads();
    model_clear();
    checks++;
    if (busy !== 1'b1 || total_events !== 32'd0 || dropped_events !== 16'd0 || sat_flag !== 1'b0) begin
      failures++;
      $display("FAIL clear_entry busy=%b total=%0d dropped=%0d sat=%b, required 1 0 0 0",
               busy, total_events, dropped_events, sat_flag);
    end
    rd_req = 1'b1;
    clear_req = 1'b1;
    tick;
    rd_req = 1'b0;
    clear_req = 1'b0;
    n = 0;
    while (busy === 1'b1 && n < 2000) begin
      tick;
      n++;
    end
    issue_read(10'd1023);
    issue_read(10'd3);
    wait_reads();
  endtask

  task automatic test_reset_midop;
    send(32'h0000_000C);
    send(32'h0000_000C);
    s_axis_tvalid = 1'b0;
    rd_req = 1'b1;
    rd_addr = 10'd3;
    tick;
    rd_req = 1'b0;
    rst_n = 1'b0;
    tick;
    tick;
    model_clear();
    checks++;
    if (busy !== 1'b1 || total_events !== 32'd0 || rd_valid !== 1'b0) begin
      failures++;
      $display("FAIL midop_reset busy=%b total=%0d rd_valid=%b, required 1 0 0",
               busy, total_events, rd_valid);
    end
    rst_n = 1'b1;
    wait_clear_done("midop_clear");
    issue_read(10'd3);
    wait_reads();
  endtask

  initial begin
    test_reset();
    test_same_bin();
    test_back_to_back();
    test_malformed();
    test_read_priority();
    test_saturate();
    test_clear();
    test_reset_midop();
    repeat (4) tick;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
